// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one full_sub_1bit cell driven LSB first with a registered borrow chain.
// Optional result flags (zero, ovf) are built when SERIAL_SUB_FLAGS_EN is defined.

module full_sub_1bit (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);
  assign d_o    = a_i ^ b_i ^ bin_i;
  assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);
endmodule

module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             done,
  output logic             busy
`ifdef SERIAL_SUB_FLAGS_EN
  ,
  output logic             zero,
  output logic             ovf
`endif
);

  localparam int               CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_sr_q, b_sr_q, d_sr_q, diff_q;
  logic [CNT_W-1:0] cnt_q;
  logic             brw_q, bout_q, done_q, busy_q, start_ready_q;
`ifdef SERIAL_SUB_FLAGS_EN
  logic             a_msb_q, b_msb_q, zero_q, ovf_q;
`endif

  logic             bit_d, bit_bo;
  logic [WIDTH-1:0] d_sr_d;

  full_sub_1bit u_fs (
    .a_i   (a_sr_q[0]),
    .b_i   (b_sr_q[0]),
    .bin_i (brw_q),
    .d_o   (bit_d),
    .bout_o(bit_bo)
  );

  // The MSB difference bit is produced on the edge that enters DONE, so results are taken from d_sr_d.
  assign d_sr_d = {bit_d, d_sr_q[WIDTH-1:1]};

  // NOTE: every register here is assigned with <= so all updates see pre-edge values of each other.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      a_sr_q        <= '0;
      b_sr_q        <= '0;
      d_sr_q        <= '0;
      diff_q        <= '0;
      cnt_q         <= '0;
      brw_q         <= 1'b0;
      bout_q        <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      start_ready_q <= 1'b1;
`ifdef SERIAL_SUB_FLAGS_EN
      a_msb_q       <= 1'b0;
      b_msb_q       <= 1'b0;
      zero_q        <= 1'b0;
      ovf_q         <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start_valid && start_ready_q) begin
            a_sr_q        <= a;
            b_sr_q        <= b;
            brw_q         <= bin;
            cnt_q         <= '0;
            busy_q        <= 1'b1;
            start_ready_q <= 1'b0;
            state_q       <= S_RUN;
`ifdef SERIAL_SUB_FLAGS_EN
            a_msb_q       <= a[WIDTH-1];
            b_msb_q       <= b[WIDTH-1];
`endif
          end
        end
        S_RUN: begin
          a_sr_q <= a_sr_q >> 1;
          b_sr_q <= b_sr_q >> 1;
          d_sr_q <= d_sr_d;
          brw_q  <= bit_bo;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BIT) begin
            diff_q  <= d_sr_d;
            bout_q  <= bit_bo;
            done_q  <= 1'b1;
            state_q <= S_DONE;
`ifdef SERIAL_SUB_FLAGS_EN
            zero_q  <= (d_sr_d == '0);
            ovf_q   <= (a_msb_q != b_msb_q) && (d_sr_d[WIDTH-1] != a_msb_q);
`endif
          end
        end
        S_DONE: begin
          busy_q        <= 1'b0;
          start_ready_q <= 1'b1;
          state_q       <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign start_ready = start_ready_q;
  assign diff        = diff_q;
  assign bout        = bout_q;
  assign done        = done_q;
  assign busy        = busy_q;
`ifdef SERIAL_SUB_FLAGS_EN
  assign zero        = zero_q;
  assign ovf         = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl (WIDTH=8): vector table, scoreboard queue, corner sequences.
// Define SERIAL_SUB_FLAGS_EN for both files to also check zero/ovf.

module tb_serial_sub_ctrl;
  localparam int W = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] diff;
    logic         bout;
    logic         zero;
    logic         ovf;
  } vec_t;

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         zero;
    logic         ovf;
    int           xfer_edge;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a, b, diff;
  logic         bin, bout, done, busy;
`ifdef SERIAL_SUB_FLAGS_EN
  logic         zero, ovf;
`endif

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   n_done = 0;
  int   n_xfer = 0;
  int   last_xfer = 0;
  int   prev_xfer = 0;
  vec_t drv;
  exp_t sb[$];
  vec_t tbl[9];

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .a          (a),
    .b          (b),
    .bin        (bin),
    .diff       (diff),
    .bout       (bout),
    .done       (done),
    .busy       (busy)
`ifdef SERIAL_SUB_FLAGS_EN
    ,
    .zero       (zero),
    .ovf        (ovf)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  function automatic vec_t make_vec(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    vec_t         v;
    logic [W:0]   r;
    r      = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, c};
    v.a    = x;
    v.b    = y;
    v.bin  = c;
    v.diff = r[W-1:0];
    v.bout = r[W];
    v.zero = (r[W-1:0] == '0);
    v.ovf  = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    return v;
  endfunction

  task automatic drive(input vec_t v);
    a   = v.a;
    b   = v.b;
    bin = v.bin;
    drv = v;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!start_ready && n < 100);
    check("ready_wait", start_ready, 1);
  endtask

  task automatic run_op(input vec_t v);
    wait_ready();
    drive(v);
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
  endtask

  // Scoreboard: push on transfer, pop and compare on done.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (done) begin
        n_done++;
        if (sb.size() == 0) begin
          check("done_unexpected", done, 0);
        end else begin
          e = sb.pop_front();
          check("diff", diff, e.diff);
          check("bout", bout, e.bout);
          check("latency", cyc - e.xfer_edge, W);
          check("busy_at_done", busy, 1);
`ifdef SERIAL_SUB_FLAGS_EN
          check("zero", zero, e.zero);
          check("ovf", ovf, e.ovf);
`endif
        end
      end
      if (start_valid && start_ready) begin
        e.diff      = drv.diff;
        e.bout      = drv.bout;
        e.zero      = drv.zero;
        e.ovf       = drv.ovf;
        e.xfer_edge = cyc + 1;
        sb.push_back(e);
        n_xfer++;
        prev_xfer = last_xfer;
        last_xfer = cyc + 1;
      end
    end
  end

  initial begin
    logic [W-1:0] corners [6];
    int n;
    corners[0] = 8'h00; corners[1] = 8'h01; corners[2] = 8'h7F;
    corners[3] = 8'h80; corners[4] = 8'hFE; corners[5] = 8'hFF;

    //              a      b      bin   diff   bout  zero  ovf
    tbl[0] = '{8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{8'h33, 8'h33, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{8'hFF, 8'h01, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
    tbl[8] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};

    rst         = 1'b1;
    start_valid = 1'b0;
    a           = '0;
    b           = '0;
    bin         = 1'b0;
    drv         = make_vec('0, '0, 1'b0);
    #3;
    check("rst_diff", diff, 0);
    check("rst_bout", bout, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", start_ready, 1);
    #9 rst = 1'b0;

    for (int i = 0; i < 9; i++) run_op(tbl[i]);

    // Hold start_valid with operands changing every cycle: only values present at each transfer count.
    wait_ready();
    drive(make_vec(8'hC8, 8'h19, 1'b0));
    start_valid = 1'b1;
    for (int i = 0; i < 2 * (W + 2) + 2; i++) begin
      @(posedge clk);
      #1;
      drive(make_vec(W'($urandom), W'($urandom), 1'($urandom)));
    end
    start_valid = 1'b0;
    check("b2b_period", last_xfer - prev_xfer, W + 2);

    // Reset in RUN cycle 3 aborts the operation.
    run_op(make_vec(8'hC3, 8'h5A, 1'b0));
    @(posedge clk);
    @(posedge clk);
    #1;
    check("busy_run", busy, 1);
    check("ready_run", start_ready, 0);
    #1 rst = 1'b1;
    #1;
    check("abort_diff", diff, 0);
    check("abort_bout", bout, 0);
    check("abort_busy", busy, 0);
    check("abort_ready", start_ready, 1);
    check("abort_done", done, 0);
    n_xfer -= sb.size();
    sb.delete();
    #1 rst = 1'b0;
    run_op(make_vec(8'hFF, 8'h01, 1'b0));

    // Corner sweep plus random operand pairs against the reference model.
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++)
        for (int c = 0; c < 2; c++)
          run_op(make_vec(corners[i], corners[j], 1'(c)));
    for (int k = 0; k < 200; k++)
      run_op(make_vec(W'($urandom), W'($urandom), 1'($urandom)));

    n = 0;
    while ((sb.size() != 0 || busy) && n < 200) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    @(negedge clk);
    check("drain", sb.size(), 0);
    check("done_count", n_done, n_xfer);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
